// File: rtl/hazard_ctrl_unit_if.sv
// rtl/hazard_ctrl_unit_if.sv - pipeline-to-hazard-unit signal bundle
interface hazard_ctrl_unit_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E;
  logic [4:0]       RdE, RdM, RdW;
  logic [1:0]       resultSrcE;
  logic             regWriteM, regWriteW;
  logic             pcSrcE;
  logic             memReqM, memReadyM;
  logic             stallF, stallD, stallE, stallM;
  logic             flushD, flushE, flushW;
  logic [1:0]       forwardAE, forwardBE;
  logic             memErr;
  logic [CNT_W-1:0] stallCnt, flushCnt;

  modport master (
    output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, resultSrcE,
           regWriteM, regWriteW, pcSrcE, memReqM, memReadyM,
    input  stallF, stallD, stallE, stallM, flushD, flushE, flushW,
           forwardAE, forwardBE, memErr, stallCnt, flushCnt
  );

  modport slave (
    input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, resultSrcE,
           regWriteM, regWriteW, pcSrcE, memReqM, memReadyM,
    output stallF, stallD, stallE, stallM, flushD, flushE, flushW,
           forwardAE, forwardBE, memErr, stallCnt, flushCnt
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - pipeline stall/flush/forward control with memory-wait timeout
module hazard_ctrl_unit #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 16
) (
  input  logic            clk,
  input  logic            rst,
  hazard_ctrl_unit_if.slave hz
);

  localparam int WC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WC_W-1:0]  wait_cnt, wait_cnt_nxt;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  logic             lw_stall, mem_stall;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e, flush_w;
  logic [1:0]       fwd_a, fwd_b;

  // M-stage result is younger than W, so it wins when both match
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      if (hz.regWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs1E)
        fwd_a = 2'b10;
      else if (hz.regWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs1E)
        fwd_a = 2'b01;
      if (hz.regWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs2E)
        fwd_b = 2'b10;
      else if (hz.regWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs2E)
        fwd_b = 2'b01;
    end
  end

  assign lw_stall  = (hz.resultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                     ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
  assign mem_stall = (state == MEM_WAIT) || (state == ERR) ||
                     ((state == RUN) && hz.memReqM && !hz.memReadyM);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      RUN: begin
        if (hz.memReqM && !hz.memReadyM) begin
          state_nxt    = MEM_WAIT;
          wait_cnt_nxt = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        if (hz.memReadyM) begin
          state_nxt    = RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == WC_W'(TIMEOUT - 1)) begin
          state_nxt    = ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + WC_W'(1);
        end
      end
      ERR:     state_nxt = ERR;
      default: begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // A memory wait freezes the whole pipe and bubbles W; lw/branch only matter otherwise
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_w = 1'b0;
    if (!rst) begin
      if (mem_stall) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        stall_e = 1'b1;
        stall_m = 1'b1;
        flush_w = 1'b1;
      end else begin
        stall_f = lw_stall;
        stall_d = lw_stall;
        flush_e = lw_stall | hz.pcSrcE;
        flush_d = hz.pcSrcE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      mem_err  <= mem_err | (state_nxt == ERR);
      if (stall_f && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush_e && flush_cnt != {CNT_W{1'b1}})
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign hz.stallF    = stall_f;
  assign hz.stallD    = stall_d;
  assign hz.stallE    = stall_e;
  assign hz.stallM    = stall_m;
  assign hz.flushD    = flush_d;
  assign hz.flushE    = flush_e;
  assign hz.flushW    = flush_w;
  assign hz.forwardAE = fwd_a;
  assign hz.forwardBE = fwd_b;
  assign hz.memErr    = mem_err;
  assign hz.stallCnt  = stall_cnt;
  assign hz.flushCnt  = flush_cnt;

endmodule
